// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse board control logic.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds the attenuator word width default and the loader state encoding.
package pulse_pkg;

    localparam int ATT_W_DEF = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT1 = 3'd1,
        ST_LATCH1 = 3'd2,
        ST_GAP1   = 3'd3,
        ST_SHIFT2 = 3'd4,
        ST_LATCH2 = 3'd5,
        ST_GAP2   = 3'd6
    } att_state_t;

    function automatic logic is_shift(input att_state_t s);
        return (s == ST_SHIFT1) || (s == ST_SHIFT2);
    endfunction

endpackage

// File: rtl/att_tick.sv
// Half-period counter for the attenuator serial bus; tick_o marks the last cycle of a phase.
// Latency: tick_o is decoded from the count register; restart_i zeroes the count on the next edge.
// Backpressure: none, free-running; the loader pulses restart_i on every state entry.
module att_tick #(
    parameter int CLK_DIV = 6
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart_i,
    output logic tick_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick_o = (cnt_q == 8'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/att_loader.sv
// Shifts the pre/post attenuator words out over a 3-wire bus and latches each device in turn.
// Latency: rxd in cycle k -> first SHIFT1 cycle k+2; a full load takes 32*CLK_DIV cycles.
// Backpressure: hold defers the start only while idle; rxd during a load queues one reload.
module att_loader
    import pulse_pkg::*;
#(
    parameter int ATT_W   = ATT_W_DEF,
    parameter int CLK_DIV = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [ATT_W-1:0] pr_att,
    input  logic [ATT_W-1:0] po_att,
    input  logic             rxd,
    input  logic             hold,
    output logic             att_clk,
    output logic             att_data,
    output logic             att_le1,
    output logic             att_le2,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(ATT_W + 1);

    att_state_t       state_q, state_d;
    logic             pending_q, pending_d;
    logic             phase_q, phase_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [ATT_W-1:0] sh1_q, sh1_d;
    logic [ATT_W-1:0] sh2_q, sh2_d;

    logic att_clk_q, att_clk_d;
    logic att_data_q, att_data_d;
    logic le1_q, le1_d;
    logic le2_q, le2_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic tick;
    logic restart;
    logic start;

    att_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .resetn   (resetn),
        .restart_i(restart),
        .tick_o   (tick)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        start   = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q && !hold) begin
                    start   = 1'b1;
                    state_d = ST_SHIFT1;
                    sh1_d   = pr_att;
                    sh2_d   = po_att;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end
            end
            ST_SHIFT1, ST_SHIFT2: begin
                // phase 0 = att_clk low, phase 1 = high; data moves only when a new low phase begins
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == BIT_W'(ATT_W - 1)) begin
                        state_d = (state_q == ST_SHIFT1) ? ST_LATCH1 : ST_LATCH2;
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_q + BIT_W'(1);
                        if (state_q == ST_SHIFT1) begin
                            sh1_d = sh1_q << 1;
                        end else begin
                            sh2_d = sh2_q << 1;
                        end
                    end
                end
            end
            ST_LATCH1: begin
                if (tick) state_d = ST_GAP1;
            end
            ST_GAP1: begin
                if (tick) begin
                    state_d = ST_SHIFT2;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end
            end
            ST_LATCH2: begin
                if (tick) state_d = ST_GAP2;
            end
            ST_GAP2: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // rxd on the departing edge wins over the clear, so a reload follows
        pending_d = (pending_q && !start) || rxd;
        restart   = (state_d != state_q);

        att_clk_d  = is_shift(state_d) && phase_d;
        att_data_d = 1'b0;
        if (state_d == ST_SHIFT1) begin
            att_data_d = sh1_d[ATT_W-1];
        end else if (state_d == ST_SHIFT2) begin
            att_data_d = sh2_d[ATT_W-1];
        end
        le1_d  = (state_d == ST_LATCH1);
        le2_d  = (state_d == ST_LATCH2);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b1;
            phase_q    <= 1'b0;
            bit_q      <= '0;
            sh1_q      <= '0;
            sh2_q      <= '0;
            att_clk_q  <= 1'b0;
            att_data_q <= 1'b0;
            le1_q      <= 1'b0;
            le2_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            sh1_q      <= sh1_d;
            sh2_q      <= sh2_d;
            att_clk_q  <= att_clk_d;
            att_data_q <= att_data_d;
            le1_q      <= le1_d;
            le2_q      <= le2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign att_clk  = att_clk_q;
    assign att_data = att_data_q;
    assign att_le1  = le1_q;
    assign att_le2  = le2_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_att_loader.sv
// Bench for att_loader at CLK_DIV=2: directed scenarios plus random rxd/hold/reset traffic,
// checked every cycle against a timeline model of the serial bus waveform.
module tb_att_loader;

    localparam int D    = 2;
    localparam int W    = 7;
    localparam int LOAD = 32 * D;

    logic         clk;
    logic         resetn;
    logic [W-1:0] pr_att;
    logic [W-1:0] po_att;
    logic         rxd;
    logic         hold;
    logic         att_clk, att_data, att_le1, att_le2, busy, done;

    int total = 0;
    int bad   = 0;

    att_loader #(
        .ATT_W  (W),
        .CLK_DIV(D)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .pr_att  (pr_att),
        .po_att  (po_att),
        .rxd     (rxd),
        .hold    (hold),
        .att_clk (att_clk),
        .att_data(att_data),
        .att_le1 (att_le1),
        .att_le2 (att_le2),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s @%0t: got 'h%0h expected 'h%0h", name, $time, act, exp);
        end
    endtask

    // Timeline model: a load started at cycle t0 has a fixed waveform vs. offset from t0.
    int           cyc = 0;
    int           m_t0 = 0;
    bit           m_started = 1'b0;
    bit           m_pending = 1'b1;
    logic [W-1:0] m_pr, m_po;
    logic [5:0]   exp_out = '0;

    always @(posedge clk) begin
        int  n, o, w, r, b;
        bit  go, idle;
        logic [W-1:0] wv;
        n = cyc;
        cyc++;
        if (!resetn) begin
            m_pending = 1'b1;
            m_started = 1'b0;
        end else begin
            idle = !m_started || (n >= m_t0 + LOAD);
            go   = idle && m_pending && !hold;
            if (go) begin
                m_t0      = n + 1;
                m_pr      = pr_att;
                m_po      = po_att;
                m_started = 1'b1;
            end
            m_pending = (m_pending && !go) || rxd;
        end
        // order: {att_clk, att_data, att_le1, att_le2, busy, done}
        exp_out = '0;
        if (m_started && cyc >= m_t0 && cyc < m_t0 + LOAD) begin
            o = cyc - m_t0;
            w = o / (16 * D);
            r = o % (16 * D);
            exp_out[1] = 1'b1;
            if (r < 14 * D) begin
                b  = r / (2 * D);
                wv = (w == 0) ? m_pr : m_po;
                exp_out[5] = ((r % (2 * D)) >= D);
                exp_out[4] = wv[W-1-b];
            end else if (r < 15 * D) begin
                if (w == 0) exp_out[3] = 1'b1;
                else        exp_out[2] = 1'b1;
            end
        end
        exp_out[0] = m_started && (cyc == m_t0 + LOAD);
    end

    // Per-cycle compare plus bus protocol rules.
    logic clk_p = 1'b0, data_p = 1'b0;
    always @(negedge clk) begin
        logic [5:0] e;
        e = resetn ? exp_out : 6'd0;
        chk("outputs", int'({att_clk, att_data, att_le1, att_le2, busy, done}), int'(e));
        if (att_clk && clk_p) chk("data_stable", int'(att_data), int'(data_p));
        chk("le_with_clk", int'((att_le1 | att_le2) & att_clk), 0);
        chk("le_both", int'(att_le1 & att_le2), 0);
        clk_p  = att_clk;
        data_p = att_data;
    end

    // Bus monitor: reconstructs latched words and event times.
    int           ncyc = 0;
    logic [W-1:0] sh_bits = '0, w1 = '0, w2 = '0;
    int           le1_cnt = 0, le1_run = 0, le1_len = 0;
    int           le2_run = 0, le2_len = 0;
    int           done_cnt = 0, busy_rises = 0, t_busy = 0, t_done = 0;
    logic         mclk_p = 0, le1_p = 0, le2_p = 0, busy_p = 0;
    always @(negedge clk) begin
        ncyc++;
        if (att_clk && !mclk_p) sh_bits = {sh_bits[W-2:0], att_data};
        if (att_le1 && !le1_p) begin w1 = sh_bits; le1_cnt++; end
        if (att_le2 && !le2_p) w2 = sh_bits;
        if (att_le1) le1_run++;
        else if (le1_p) begin le1_len = le1_run; le1_run = 0; end
        if (att_le2) le2_run++;
        else if (le2_p) begin le2_len = le2_run; le2_run = 0; end
        if (busy && !busy_p) begin busy_rises++; t_busy = ncyc; end
        if (done) begin done_cnt++; t_done = ncyc; end
        mclk_p = att_clk;
        le1_p  = att_le1;
        le2_p  = att_le2;
        busy_p = busy;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int i  = 0;
        while (done_cnt == d0 && i < budget) begin
            step();
            i++;
        end
        chk("done_timeout", int'(done_cnt != d0), 1);
    endtask

    initial begin
        int d0, br, l1, first_done;
        resetn = 1'b0;
        pr_att = 7'h55;
        po_att = 7'h2A;
        rxd    = 1'b0;
        hold   = 1'b0;
        repeat (3) step();
        chk("reset_out", int'({att_clk, att_data, att_le1, att_le2, busy, done}), 0);

        // power-up load
        resetn = 1'b1;
        wait_done(200);
        chk("pwr_word1", int'(w1), 'h55);
        chk("pwr_word2", int'(w2), 'h2A);
        chk("pwr_le1_len", le1_len, 2);
        chk("pwr_le2_len", le2_len, 2);
        chk("pwr_busy_to_done", t_done - t_busy, 64);

        // hold deferral
        repeat (5) step();
        hold = 1'b1;
        rxd  = 1'b1;
        step();
        rxd = 1'b0;
        br  = busy_rises;
        repeat (40) step();
        chk("hold_defer", busy_rises - br, 0);
        hold = 1'b0;
        step();
        chk("hold_release_busy", int'(busy), 1);
        chk("hold_first_bit", int'(att_data), 1);
        wait_done(200);

        // rxd mid-transfer (during SHIFT2)
        repeat (3) step();
        rxd = 1'b1;
        step();
        rxd = 1'b0;
        repeat (42) step();
        pr_att = 7'h7F;
        rxd    = 1'b1;
        step();
        rxd = 1'b0;
        wait_done(200);
        chk("mid_old_word1", int'(w1), 'h55);
        chk("mid_old_word2", int'(w2), 'h2A);
        first_done = t_done;
        wait_done(200);
        chk("mid_new_word1", int'(w1), 'h7F);
        chk("mid_back_to_back", t_busy, first_done + 1);

        // rxd on the edge that leaves IDLE
        repeat (3) step();
        d0   = done_cnt;
        hold = 1'b1;
        rxd  = 1'b1;
        step();
        rxd = 1'b0;
        step();
        hold = 1'b0;
        rxd  = 1'b1;
        step();
        rxd = 1'b0;
        repeat (220) step();
        chk("simul_two_loads", done_cnt - d0, 2);

        // reset during bit 3 of SHIFT1
        pr_att = 7'h55;
        rxd    = 1'b1;
        step();
        rxd = 1'b0;
        repeat (14) step();
        l1     = le1_cnt;
        d0     = done_cnt;
        resetn = 1'b0;
        #1;
        chk("rst_mid_out", int'({att_clk, att_data, att_le1, att_le2, busy, done}), 0);
        step();
        step();
        resetn = 1'b1;
        wait_done(200);
        chk("rst_reload_le1", le1_cnt - l1, 1);
        chk("rst_reload_done", done_cnt - d0, 1);
        chk("rst_reload_word1", int'(w1), 'h55);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29) == 0) hold = ~hold;
            rxd = ($urandom_range(24) == 0);
            if (rxd) begin
                pr_att = W'($urandom);
                po_att = W'($urandom);
            end
            if ($urandom_range(1499) == 0) begin
                resetn = 1'b0;
                repeat ($urandom_range(1, 3)) step();
                resetn = 1'b1;
            end
            step();
        end
        rxd  = 1'b0;
        hold = 1'b0;
        repeat (200) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
